serial_adder: RTL and testbench

Bit-serial ripple adder that consumes one bit-pair per clock, LSB first.
Operands enter through a valid/ready handshake. The result leaves through a second valid/ready handshake.
Each bit slice is a full adder built from two of the team's half_adder cells plus one carry register, trading latency for area in the arithmetic datapath.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/full_adder_bit.sv | 32 +++
 rtl/half_adder.sv | 15 +
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
//   state_e      : controller state encoding (2 bits)
//   DefaultWidth : default operand/result width
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half_adder cells and an OR of their carries.
//   a, b, ci : input bits and carry-in
//   s        : a ^ b ^ ci
//   co       : carry-out
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a(a),
    .b(b),
    .s(s0),
    .c(c0)
  );

  half_adder u_ha1 (
    .a(s0),
    .b(ci),
    .s(s),
    .c(c1)
  );

  // Both carries can never be high together, so OR is an exact merge.
  assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder cell.
//   a, b : input bits
//   s    : a ^ b
//   c    : a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per clock, LSB first.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b, cin)
//   out_valid/out_ready  : result handshake (sum, cout)
//   sum                  : a + b + cin modulo 2^WIDTH
//   cout                 : carry out of bit WIDTH-1
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q, sum_d;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q;
  logic             fa_s, fa_co;
  logic             last_bit;

  full_adder_bit u_fa (
    .a (a_sh_q[0]),
    .b (b_sh_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_co)
  );

  assign last_bit = (cnt_q == CntLast);

  // New bit enters at the MSB; after WIDTH shifts the LSB result sits at bit 0.
  // Shift form avoids a zero-width slice when WIDTH == 1.
  assign sum_d = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StRun;
      StRun:  if (last_bit) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: pure function of state
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Datapath: shift registers, carry, counter and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CntW'(1);
          if (last_bit) cout_q <= fa_co;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [W-1:0] a, b, sum;

  // WIDTH=1 instance
  logic         iv1, ir1, ov1, or1, cin1, cout1;
  logic [0:0]   a1, b1, sum1;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   last_acc = 0;
  logic acc_pending = 1'b0;
  logic prev_acc_ok = 1'b0;
  logic stream_mode = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (iv1),
    .in_ready (ir1),
    .a        (a1),
    .b        (b1),
    .cin      (cin1),
    .out_valid(ov1),
    .out_ready(or1),
    .sum      (sum1),
    .cout     (cout1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    exp_t e;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    return e;
  endfunction

  // Inputs for the coming edge must already be set. Scores the transfer/accept
  // that this edge performs, then advances one cycle and samples #1 later.
  task automatic tick();
    logic acc, xfer, ov_prev;
    exp_t e;
    acc     = rst_n && in_valid && in_ready;
    xfer    = rst_n && out_valid && out_ready;
    ov_prev = out_valid;
    if (xfer) begin
      check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("sum", 32'(sum), 32'(e.sum));
        check_eq("cout", 32'(cout), 32'(e.cout));
      end
    end
    if (acc) begin
      sb.push_back(model(a, b, cin));
      if (stream_mode && prev_acc_ok) check_eq("accept_spacing", 32'(cyc + 1 - last_acc), W + 2);
      last_acc    = cyc + 1;
      prev_acc_ok = 1'b1;
      acc_cyc     = cyc + 1;
      acc_pending = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (xfer) check_eq("out_valid_one_cycle", 32'(out_valid), 32'd0);
    // Latency counts edges from the accepting edge through the DONE-entry edge.
    if (out_valid && !ov_prev && acc_pending) begin
      check_eq("latency", 32'(cyc - acc_cyc + 1), W + 1);
      acc_pending = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Inputs ignored while in reset
    in_valid = 1'b1; a = 8'h5A;
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: basic add, latency, single-cycle out_valid
    do_op(8'h03, 8'h05, 1'b0);
    // 2: wrap-around
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);

    // 3: backpressure with in_valid pulsing
    out_ready = 1'b0;
    a = 8'h7F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 8'h11; b = 8'h22;
      tick();
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_sum", 32'(sum), 32'h80);
      check_eq("bp_cout", 32'(cout), 32'd0);
    end
    check_eq("bp_no_extra_accept", 32'(sb.size()), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("bp_back_idle", 32'(in_ready), 32'd1);
    check_eq("bp_sum_held", 32'(sum), 32'h80);

    // 4: reset during the 4th RUN cycle
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    sb.delete();
    acc_pending = 1'b0;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_sum", 32'(sum), 32'd0);
    check_eq("midrst_cout", 32'(cout), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    do_op(8'h10, 8'h20, 1'b0);

    // 5: streaming with in_valid held
    begin
      logic [W-1:0] oa[3] = '{8'h01, 8'h80, 8'h0F};
      logic [W-1:0] ob[3] = '{8'h01, 8'h80, 8'hF0};
      int k = 0;
      int n = 0;
      stream_mode = 1'b1;
      prev_acc_ok = 1'b0;
      in_valid = 1'b1;
      while ((k < 3 || sb.size() != 0 || out_valid) && n < 100) begin
        if (in_ready) begin
          if (k < 3) begin
            a = oa[k]; b = ob[k]; cin = 1'b0; in_valid = 1'b1;
            k++;
          end else begin
            in_valid = 1'b0;
          end
        end
        tick();
        n++;
      end
      in_valid = 1'b0;
      stream_mode = 1'b0;
      check_eq("stream_timeout", 32'(n < 100), 32'd1);
      check_eq("stream_all_sent", 32'(k), 32'd3);
    end

    // 6: WIDTH=1 instance
    begin
      int n = 1;
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
      check_eq("w1_in_ready", 32'(ir1), 32'd1);
      @(posedge clk);
      #1;
      iv1 = 1'b0;
      while (!ov1 && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      check_eq("w1_latency", 32'(n), 32'd2);
      check_eq("w1_sum", 32'(sum1), 32'd1);
      check_eq("w1_cout", 32'(cout1), 32'd1);
      @(posedge clk);
      #1;
      check_eq("w1_out_valid_drop", 32'(ov1), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
